i2c_master_tx: RTL and testbench

- I2C write initiator; the bus-driving end that the team's Slave receiver listens to.
- On a START pulse it generates an I2C START, shifts out one 8-bit address/control byte, samples ACK, shifts out one data byte, samples ACK, then generates STOP.
- Drives SCL push-pull (no clock stretching) and SDA open-drain on a shared inout line.
- Used as the synthesizable stimulus/initiator for Slave bring-up and as the on-chip master in later I2C work.

---
 rtl/i2c_master_tx.sv | 183 ++++++++++++++++++
 tb/tb_i2c_master_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_tx.sv
// I2C write initiator: START, one address byte, ACK, one data byte, ACK, STOP.
// SCL is push-pull; SDA is open-drain and is only ever pulled low or released.
module i2c_master_tx #(
  parameter int CLK_DIV   = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [7:0] ADDR,
  input  logic [7:0] DATA_IN,
  output logic       SCL,
  inout  wire        SDA,
  output logic       BUSY,
  output logic       DONE,
  output logic       NACK
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STA, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STP, S_FIN
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [1:0]       q_reg, q_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       data_reg, data_next;
  logic             nack_reg, nack_next;
  logic             scl_reg, scl_next;
  logic             sda_oe_reg, sda_oe_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             tick, sample, slot_end;
  logic [7:0]       tx_byte;
  logic [2:0]       tx_idx;
  logic             tx_bit;

  assign tick     = (div_reg == DIV_MAX);
  assign sample   = tick && (q_reg == 2'd2);
  assign slot_end = tick && (q_reg == 2'd3);

  always_comb begin
    state_next  = state_reg;
    div_next    = div_reg;
    q_next      = q_reg;
    bit_next    = bit_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    nack_next   = nack_reg;
    scl_next    = 1'b1;
    sda_oe_next = 1'b0;
    tx_byte     = 8'h00;
    tx_idx      = 3'd0;
    tx_bit      = 1'b1;

    // Divider and quarter index only run while a transaction is in flight.
    if (state_reg == S_IDLE || state_reg == S_FIN) begin
      div_next = '0;
      q_next   = 2'd0;
    end else begin
      div_next = tick ? '0 : div_reg + DIV_W'(1);
      if (tick) q_next = q_reg + 2'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (START) begin
          addr_next  = ADDR;
          data_next  = DATA_IN;
          nack_next  = 1'b0;
          bit_next   = 3'd0;
          state_next = S_STA;
        end
      end
      S_STA: begin
        if (slot_end) begin
          bit_next   = 3'd0;
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (slot_end) begin
          bit_next = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = S_ACK1;
        end
      end
      S_ACK1: begin
        if (sample && SDA) nack_next = 1'b1;
        // The sample lands one quarter before slot_end, so nack_reg is current here.
        if (slot_end) state_next = nack_reg ? S_STP : S_DATA;
      end
      S_DATA: begin
        if (slot_end) begin
          bit_next = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = S_ACK2;
        end
      end
      S_ACK2: begin
        if (sample && SDA) nack_next = 1'b1;
        if (slot_end) state_next = S_STP;
      end
      S_STP: begin
        if (slot_end) state_next = S_FIN;
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Pin levels are decoded from the next state so they register glitch-free
    // and line up exactly with the state they belong to.
    tx_byte = (state_next == S_ADDR) ? addr_next : data_next;
    tx_idx  = LSB_FIRST ? bit_next : (3'd7 - bit_next);
    tx_bit  = tx_byte[tx_idx];

    case (state_next)
      S_STA: begin
        scl_next    = 1'b1;
        sda_oe_next = q_next[1];
      end
      S_ADDR, S_DATA: begin
        scl_next    = q_next[1];
        sda_oe_next = ~tx_bit;
      end
      S_ACK1, S_ACK2: begin
        scl_next    = q_next[1];
        sda_oe_next = 1'b0;
      end
      S_STP: begin
        scl_next    = q_next[1];
        sda_oe_next = (q_next != 2'd3);
      end
      default: begin
        scl_next    = 1'b1;
        sda_oe_next = 1'b0;
      end
    endcase

    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_FIN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= S_IDLE;
      div_reg    <= '0;
      q_reg      <= 2'd0;
      bit_reg    <= 3'd0;
      addr_reg   <= 8'h00;
      data_reg   <= 8'h00;
      nack_reg   <= 1'b0;
      scl_reg    <= 1'b1;
      sda_oe_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      div_reg    <= div_next;
      q_reg      <= q_next;
      bit_reg    <= bit_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      nack_reg   <= nack_next;
      scl_reg    <= scl_next;
      sda_oe_reg <= sda_oe_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign SCL  = scl_reg;
  assign SDA  = sda_oe_reg ? 1'b0 : 1'bz;
  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign NACK = nack_reg;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx: two instances (LSB-first CLK_DIV=2, MSB-first CLK_DIV=1)
// with a bus decoder and ACK responder per instance.
module tb_i2c_master_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] addr0 = 8'h00, data0 = 8'h00, addr1 = 8'h00, data1 = 8'h00;
  logic       scl0, scl1, busy0, busy1, done0, done1, nack0, nack1;
  wire        sda0, sda1;

  logic       resp [2] = '{1'b0, 1'b0};
  logic [1:0] ack_en [2] = '{2'b00, 2'b00};

  assign sda0 = resp[0] ? 1'b0 : 1'bz;
  assign sda1 = resp[1] ? 1'b0 : 1'bz;
  pullup (sda0);
  pullup (sda1);

  i2c_master_tx #(.CLK_DIV(2), .LSB_FIRST(1'b1)) dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start0), .ADDR(addr0), .DATA_IN(data0),
    .SCL(scl0), .SDA(sda0), .BUSY(busy0), .DONE(done0), .NACK(nack0)
  );

  i2c_master_tx #(.CLK_DIV(1), .LSB_FIRST(1'b0)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .ADDR(addr1), .DATA_IN(data1),
    .SCL(scl1), .SDA(sda1), .BUSY(busy1), .DONE(done1), .NACK(nack1)
  );

  // Bus decoder: bits are captured on SCL rising; SDA edges while SCL stays high
  // are START/STOP. bitv[k][i] holds the i-th bit seen on the wire since START.
  int          nbits  [2] = '{0, 0};
  logic [31:0] bitv   [2] = '{32'h0, 32'h0};
  int          starts [2] = '{0, 0};
  int          stops  [2] = '{0, 0};
  logic        pscl   [2] = '{1'b1, 1'b1};
  logic        psda   [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int          n;
      logic [31:0] bv;
      logic        cs, cd, drive;
      cs = (k == 0) ? scl0 : scl1;
      cd = (k == 0) ? (sda0 === 1'b1) : (sda1 === 1'b1);
      n  = nbits[k];
      bv = bitv[k];
      if (pscl[k] && cs && psda[k] && !cd) begin
        starts[k] <= starts[k] + 1;
        n  = 0;
        bv = 32'h0;
      end else if (pscl[k] && cs && !psda[k] && cd) begin
        stops[k] <= stops[k] + 1;
      end else if (!pscl[k] && cs) begin
        if (n < 32) bv[n] = cd;
        n++;
      end
      nbits[k] <= n;
      bitv[k]  <= bv;
      pscl[k]  <= cs;
      psda[k]  <= cd;
      drive = (ack_en[k][0] && ((n == 8 && !cs) || (n == 9 && cs))) ||
              (ack_en[k][1] && ((n == 17 && !cs) || (n == 18 && cs)));
      resp[k] <= drive;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input int k, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    if (k == 0) begin addr0 = a; data0 = d; start0 = 1'b1; end
    else        begin addr1 = a; data1 = d; start1 = 1'b1; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int k, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!((k == 0) ? done0 : done1) && cyc < limit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int idle_err;
    int st0, sp0;

    // Reset and idle bus
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl0, 1);
    chk("rst_sda", sda0, 1);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    idle_err = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (scl0 !== 1'b1 || sda0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || nack0 !== 1'b0 ||
          scl1 !== 1'b1 || sda1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || nack1 !== 1'b0)
        idle_err++;
    end
    chk("idle_50", idle_err, 0);

    // Txn A: LSB first, CLK_DIV=2, both ACKed
    ack_en[0] = 2'b11;
    st0 = starts[0]; sp0 = stops[0];
    start_txn(0, 8'h33, 8'hA5);
    chk("A_busy", busy0, 1);
    wait_done(0, 400, cyc);
    $display("txn A: cycles=%0d nbits=%0d addr=%0h data=%0h nack=%0d", cyc, nbits[0], bitv[0][7:0], bitv[0][16:9], nack0);
    chk("A_latency", cyc, 160);
    chk("A_nack", nack0, 0);
    chk("A_nbits", nbits[0], 19);
    chk("A_addr", bitv[0][7:0], 8'h33);
    chk("A_ack1", bitv[0][8], 0);
    chk("A_data", bitv[0][16:9], 8'hA5);
    chk("A_ack2", bitv[0][17], 0);
    chk("A_start", starts[0] - st0, 1);
    chk("A_stop", stops[0] - sp0, 1);
    @(posedge clk); #1;
    chk("A_done_pulse", done0, 0);
    chk("A_busy_after", busy0, 0);

    // Txn B: MSB first, CLK_DIV=1, both ACKed
    ack_en[1] = 2'b11;
    start_txn(1, 8'h33, 8'hA5);
    chk("B_busy", busy1, 1);
    wait_done(1, 200, cyc);
    $display("txn B: cycles=%0d nbits=%0d addr=%0h data=%0h nack=%0d", cyc, nbits[1], bitv[1][7:0], bitv[1][16:9], nack1);
    chk("B_latency", cyc, 80);
    chk("B_nack", nack1, 0);
    chk("B_nbits", nbits[1], 19);
    chk("B_addr_wire", bitv[1][7:0], 8'hCC);
    chk("B_data_wire", bitv[1][16:9], 8'hA5);
    chk("B_acks", {bitv[1][17], bitv[1][8]}, 2'b00);

    // Txn C: address not acknowledged
    ack_en[0] = 2'b00;
    sp0 = stops[0];
    start_txn(0, 8'h33, 8'h5A);
    wait_done(0, 400, cyc);
    $display("txn C: cycles=%0d nbits=%0d addr=%0h nack=%0d", cyc, nbits[0], bitv[0][7:0], nack0);
    chk("C_latency", cyc, 88);
    chk("C_nack", nack0, 1);
    chk("C_nbits", nbits[0], 10);
    chk("C_addr", bitv[0][7:0], 8'h33);
    chk("C_ack_stp", bitv[0][9:8], 2'b01);
    chk("C_stop", stops[0] - sp0, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("C_nack_hold", nack0, 1);

    // Txn D: START re-pulse mid-address, then reset during data bit 3
    ack_en[0] = 2'b11;
    start_txn(0, 8'h33, 8'hA5);
    chk("D_nack_clr", nack0, 0);
    cyc = 0;
    while (nbits[0] < 3 && cyc < 400) begin @(posedge clk); #1; cyc++; end
    chk("D_reach_addr", cyc < 400, 1);
    addr0 = 8'hFF; data0 = 8'h00; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("D_busy_repulse", busy0, 1);
    cyc = 0;
    while (!(nbits[0] == 12 && scl0 == 1'b0) && cyc < 400) begin @(posedge clk); #1; cyc++; end
    $display("txn D: nbits=%0d addr=%0h sda=%0b before reset", nbits[0], bitv[0][7:0], sda0);
    chk("D_reach_d3", cyc < 400, 1);
    chk("D_addr_kept", bitv[0][7:0], 8'h33);
    chk("D_d3_low", sda0, 0);
    rst_n = 1'b0;
    #1;
    chk("D_rst_scl", scl0, 1);
    chk("D_rst_sda", sda0, 1);
    chk("D_rst_busy", busy0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Txn E: normal transaction after the abort
    sp0 = stops[0];
    start_txn(0, 8'h5C, 8'h3E);
    wait_done(0, 400, cyc);
    $display("txn E: cycles=%0d nbits=%0d addr=%0h data=%0h nack=%0d", cyc, nbits[0], bitv[0][7:0], bitv[0][16:9], nack0);
    chk("E_latency", cyc, 160);
    chk("E_nack", nack0, 0);
    chk("E_nbits", nbits[0], 19);
    chk("E_addr", bitv[0][7:0], 8'h5C);
    chk("E_data", bitv[0][16:9], 8'h3E);
    chk("E_stop", stops[0] - sp0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
